// File: rtl/nibble_latch_writer.sv
// -----------------------------------------------------------------------------
// nibble_latch_writer
//
// Write-side sequencer for a bank of NIBBLES level-sensitive 4-bit latches.
// A word is accepted over a valid/ready handshake, split into nibbles, and the
// nibbles selected by the mask are written one at a time over a shared 4-bit
// bus. Each write is framed as SETUP (data stable, strobe low), PULSE (strobe
// high) and HOLD (data stable, strobe low), so every latch sees clean setup
// and hold around its load strobe. All outputs come straight from flops.
//
// Ports
//   clk         system clock, rising edge
//   reset       synchronous, active-high reset
//   in_valid    word and mask are valid
//   in_ready    block can accept a word (high only when idle)
//   in_word     NIBBLES*4-bit word, nibble i = in_word[4i+3:4i]
//   in_mask     bit i set = write latch i, clear = skip it
//   latch_d     shared 4-bit data bus to all latches
//   latch_load  one-hot load strobe, bit i drives latch i
//   busy        high from the accept edge until done deasserts
//   done        one-cycle pulse when a sequence completes
// -----------------------------------------------------------------------------
module nibble_latch_writer #(
  parameter int NIBBLES   = 4,
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NIBBLES*4-1:0]   in_word,
  input  logic [NIBBLES-1:0]     in_mask,
  output logic [3:0]             latch_d,
  output logic [NIBBLES-1:0]     latch_load,
  output logic                   busy,
  output logic                   done
);

  // Longest phase sets the counter width; the counter runs from N-1 down to 0.
  localparam int MAX_SP  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int MAX_CYC = (MAX_SP > HOLD_CYC) ? MAX_SP : HOLD_CYC;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_HOLD,
    S_DONE
  } state_e;

  state_e                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [NIBBLES*4-1:0]   word_q;
  logic [NIBBLES-1:0]     rem_q;     // mask bits still to be written
  logic [IDX_W-1:0]       idx_q;     // latch currently being written
  logic                   in_ready_q;
  logic [3:0]             latch_d_q;
  logic [NIBBLES-1:0]     latch_load_q;
  logic                   busy_q;
  logic                   done_q;

  // Next nibble selection, shared by the accept path (fresh inputs) and the
  // HOLD path (captured word, remaining mask).
  logic [NIBBLES-1:0]     src_mask_d;
  logic [NIBBLES*4-1:0]   src_word_d;
  logic [IDX_W-1:0]       idx_d;
  logic [NIBBLES-1:0]     rem_d;
  logic [3:0]             nib_d;

  function automatic logic [IDX_W-1:0] lowest_set(input logic [NIBBLES-1:0] m);
    lowest_set = '0;
    for (int i = NIBBLES - 1; i >= 0; i--) begin
      if (m[i]) lowest_set = IDX_W'(i);
    end
  endfunction

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    src_mask_d = rem_q;
    src_word_d = word_q;
    if (state_q == S_IDLE) begin
      src_mask_d = in_mask;
      src_word_d = in_word;
    end
    idx_d = lowest_set(src_mask_d);
    // Clearing the lowest set bit leaves exactly the nibbles still pending.
    rem_d = src_mask_d & (src_mask_d - NIBBLES'(1));
    nib_d = src_word_d[{idx_d, 2'b00} +: 4];
  end

  // NOTE: the captured word is pure datapath, qualified by the FSM, so it
  // carries no reset; only control state and outputs are reset.
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && in_valid) word_q <= in_word;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      rem_q        <= '0;
      idx_q        <= '0;
      in_ready_q   <= 1'b1;
      latch_d_q    <= '0;
      latch_load_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // in_ready_q is high throughout IDLE, so in_valid alone is accept.
          if (in_valid) begin
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            if (in_mask != '0) begin
              state_q   <= S_SETUP;
              cnt_q     <= SETUP_LAST;
              idx_q     <= idx_d;
              rem_q     <= rem_d;
              latch_d_q <= nib_d;
            end else begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        S_SETUP: begin
          if (cnt_q == '0) begin
            state_q      <= S_PULSE;
            cnt_q        <= PULSE_LAST;
            latch_load_q <= NIBBLES'(1) << idx_q;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_PULSE: begin
          if (cnt_q == '0) begin
            state_q      <= S_HOLD;
            cnt_q        <= HOLD_LAST;
            latch_load_q <= '0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_HOLD: begin
          if (cnt_q == '0) begin
            if (rem_q != '0) begin
              // The bus only changes here, a full HOLD period after the
              // strobe fell.
              state_q   <= S_SETUP;
              cnt_q     <= SETUP_LAST;
              idx_q     <= idx_d;
              rem_q     <= rem_d;
              latch_d_q <= nib_d;
            end else begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_DONE: begin
          state_q    <= S_IDLE;
          done_q     <= 1'b0;
          busy_q     <= 1'b0;
          in_ready_q <= 1'b1;
        end
        default: begin
          state_q      <= S_IDLE;
          latch_load_q <= '0;
          in_ready_q   <= 1'b1;
          busy_q       <= 1'b0;
          done_q       <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign latch_d    = latch_d_q;
  assign latch_load = latch_load_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_nibble_latch_writer.sv
// -----------------------------------------------------------------------------
// tb_nibble_latch_writer
//
// Bench for nibble_latch_writer. The reference model expands every accepted
// word into the expected per-cycle timeline of (latch_d, latch_load, busy,
// done, in_ready) and compares the DUT against it cycle by cycle. A model of
// the downstream latch bank is driven from the DUT outputs and compared with
// the contents the written words imply. Directed cases come first, then a
// randomized run.
// -----------------------------------------------------------------------------
module tb_nibble_latch_writer;

  localparam int N = 4;
  localparam int S = 1;
  localparam int P = 2;
  localparam int H = 1;
  localparam int T = S + P + H;

  logic           clk = 1'b0;
  logic           reset;
  logic           in_valid;
  logic           in_ready;
  logic [N*4-1:0] in_word;
  logic [N-1:0]   in_mask;
  logic [3:0]     latch_d;
  logic [N-1:0]   latch_load;
  logic           busy;
  logic           done;

  nibble_latch_writer #(
    .NIBBLES  (N),
    .SETUP_CYC(S),
    .PULSE_CYC(P),
    .HOLD_CYC (H)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_word   (in_word),
    .in_mask   (in_mask),
    .latch_d   (latch_d),
    .latch_load(latch_load),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]   d;
    logic [N-1:0] load;
    logic         busy;
    logic         done;
    logic         ready;
  } obs_t;

  obs_t       exp_q[$];
  obs_t       exp_o;
  int         cyc;
  int         acc_cyc;
  int         acc_k;
  int         n_checks;
  int         n_pass;
  logic [3:0] ref_bank [N];
  logic [3:0] dut_bank [N];
  logic [3:0] prev_d;
  logic [N-1:0] prev_load;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s (cycle %0d): got %0h, expected %0h", tag, cyc, got, want);
  endtask

  // Advance the model by one clock edge using the inputs driven for it.
  task automatic model_step();
    logic [3:0] last;
    int k;
    cyc++;
    if (reset) begin
      exp_q.delete();
      exp_o = '{d: 4'h0, load: '0, busy: 1'b0, done: 1'b0, ready: 1'b1};
      return;
    end
    if (exp_o.ready && in_valid) begin
      acc_cyc = cyc;
      last    = exp_o.d;
      k       = 0;
      for (int i = 0; i < N; i++) begin
        if (in_mask[i]) begin
          logic [3:0] nib;
          nib = in_word[4*i +: 4];
          for (int s = 0; s < S; s++) exp_q.push_back('{nib, '0, 1'b1, 1'b0, 1'b0});
          for (int p = 0; p < P; p++) exp_q.push_back('{nib, N'(1) << i, 1'b1, 1'b0, 1'b0});
          for (int h = 0; h < H; h++) exp_q.push_back('{nib, '0, 1'b1, 1'b0, 1'b0});
          last = nib;
          k++;
        end
      end
      exp_q.push_back('{last, '0, 1'b1, 1'b1, 1'b0});
      acc_k = k;
    end
    if (exp_q.size() > 0) exp_o = exp_q.pop_front();
    else exp_o = '{d: exp_o.d, load: '0, busy: 1'b0, done: 1'b0, ready: 1'b1};
    for (int i = 0; i < N; i++) if (exp_o.load[i]) ref_bank[i] = exp_o.d;
  endtask

  task automatic compare();
    check("latch_d",    latch_d,    exp_o.d);
    check("latch_load", latch_load, exp_o.load);
    check("busy",       busy,       exp_o.busy);
    check("done",       done,       exp_o.done);
    check("in_ready",   in_ready,   exp_o.ready);
    check("load_onehot0", $onehot0(latch_load), 1);
    if (!reset && (prev_load != '0 || latch_load != '0))
      check("d_stable_at_load", latch_d, prev_d);
    for (int i = 0; i < N; i++) if (latch_load[i]) dut_bank[i] = latch_d;
    if (done) check("done_latency", cyc - acc_cyc + 1, acc_k * T + 1);
    if (exp_o.done) begin
      for (int i = 0; i < N; i++) check($sformatf("bank%0d", i), dut_bank[i], ref_bank[i]);
    end
    prev_d    = latch_d;
    prev_load = latch_load;
  endtask

  task automatic step(input logic rst, input logic v, input logic [N*4-1:0] w,
                      input logic [N-1:0] m);
    reset    = rst;
    in_valid = v;
    in_word  = w;
    in_mask  = m;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, N*4'($urandom), N'($urandom));
  endtask

  initial begin
    bit found;
    n_checks  = 0;
    n_pass    = 0;
    cyc       = 0;
    acc_cyc   = 0;
    acc_k     = 0;
    prev_d    = '0;
    prev_load = '0;
    exp_o     = '{d: 4'h0, load: '0, busy: 1'b0, done: 1'b0, ready: 1'b1};
    for (int i = 0; i < N; i++) begin
      ref_bank[i] = '0;
      dut_bank[i] = '0;
    end

    // Reset then idle.
    step(1'b1, 1'b0, '0, '0);
    step(1'b1, 1'b0, '0, '0);
    idle_cycles(2);

    // Full write: 3,C,5,A into latches 0..3; inputs churn while busy.
    step(1'b0, 1'b1, 16'hA5C3, 4'b1111);
    idle_cycles(20);

    // Sparse mask: only latches 1 and 3, values 3 then 1.
    step(1'b0, 1'b1, 16'h1234, 4'b1010);
    idle_cycles(12);

    // Empty mask: done in cycle 1, ready again in cycle 2.
    step(1'b0, 1'b1, 16'hFFFF, 4'b0000);
    idle_cycles(3);

    // Back-to-back with in_valid held high and the word changing every cycle.
    for (int i = 0; i < 45; i++) step(1'b0, 1'b1, N*4'($urandom), 4'b1111);
    idle_cycles(20);

    // Reset while latch 2 is being strobed.
    step(1'b0, 1'b1, 16'h9876, 4'b1111);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (latch_load == 4'b0100) found = 1'b1;
      else idle_cycles(1);
    end
    check("reached_pulse2", found, 1'b1);
    step(1'b1, 1'b0, '0, '0);
    idle_cycles(2);
    step(1'b0, 1'b1, 16'h4321, 4'b1111);
    idle_cycles(20);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 79) == 0, $urandom_range(0, 3) != 0,
           N*4'($urandom), N'($urandom));
    end
    idle_cycles(20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
